// File: rtl/param_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : param_stage_chain
// Purpose  : Chain of STAGES data stages between a valid/ready producer and
//            consumer. Each stage is a combinational passthrough or a
//            registered 2-entry elastic buffer, selected by REG_MASK.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of every registered stage
//   in_valid   upstream beat valid
//   in_data    upstream beat (WIDTH bits)
//   in_ready   chain accepts a beat this cycle
//   out_valid  downstream beat valid
//   out_data   downstream beat (WIDTH bits)
//   out_ready  downstream accepts a beat this cycle
//   occupancy  beats held across all registered stages (OCC_W bits)
// ============================================================================
module param_stage_chain #(
    parameter int                WIDTH    = 8,
    parameter int                STAGES   = 2,
    parameter logic [STAGES-1:0] REG_MASK = 2'b01,
    parameter int                OCC_W    = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    // Per-stage state. Passthrough stages keep their count at 0 forever and
    // never write storage, so their state folds away.
    logic [STAGES-1:0][1:0]       r_cnt;
    logic [STAGES-1:0]            r_wp;
    logic [STAGES-1:0]            r_rp;
    logic [WIDTH-1:0]             r_mem [STAGES][2];
    logic [OCC_W-1:0]             r_occ;

    // Per-stage interface as seen by each stage
    logic [STAGES-1:0]            w_in_valid;
    logic [STAGES-1:0][WIDTH-1:0] w_in_data;
    logic [STAGES-1:0]            w_out_ready;
    logic [STAGES-1:0]            w_push;
    logic [STAGES-1:0]            w_pop;
    logic [STAGES-1:0][1:0]       w_cnt_nxt;
    logic [OCC_W-1:0]             w_occ_nxt;

    // Running values while walking the chain
    logic                         w_v;
    logic [WIDTH-1:0]             w_d;
    logic                         w_r;

    always_comb begin
        w_in_valid  = '0;
        w_in_data   = '0;
        w_out_ready = '0;
        w_push      = '0;
        w_pop       = '0;
        w_cnt_nxt   = '0;
        w_occ_nxt   = '0;

        // Forward walk: valid/data come only from registered heads or the
        // upstream port, so a passthrough stage just forwards what it sees.
        w_v = in_valid;
        w_d = in_data;
        for (int i = 0; i < STAGES; i++) begin
            w_in_valid[i] = w_v;
            w_in_data[i]  = w_d;
            if (REG_MASK[i]) begin
                w_v = (r_cnt[i] != 2'd0);
                // Empty registered stage drives zeros instead of stale storage
                w_d = w_v ? r_mem[i][r_rp[i]] : '0;
            end
        end

        // Backward walk: a registered stage breaks the ready path; its
        // in_ready depends only on its own count register.
        w_r = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_out_ready[i] = w_r;
            if (REG_MASK[i]) begin
                w_r = (r_cnt[i] != 2'd2);
            end
        end

        // Count update; a push and a pop on the same edge cancel out
        for (int i = 0; i < STAGES; i++) begin
            w_push[i]    = REG_MASK[i] & w_in_valid[i] & (r_cnt[i] != 2'd2) & ~flush;
            w_pop[i]     = REG_MASK[i] & (r_cnt[i] != 2'd0) & w_out_ready[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (flush) begin
                w_cnt_nxt[i] = 2'd0;
            end else if (w_push[i] && !w_pop[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + 2'd1;
            end else if (!w_push[i] && w_pop[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - 2'd1;
            end
            w_occ_nxt = w_occ_nxt + OCC_W'(w_cnt_nxt[i]);
        end
    end

    // Flush masks the upstream handshake even when stage 0 is a passthrough
    assign in_ready  = w_r & ~flush;
    assign out_valid = w_v;
    assign out_data  = w_d;
    assign occupancy = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_occ <= w_occ_nxt;
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    // Realign pointers so the emptied stage restarts cleanly
                    r_wp[i] <= 1'b0;
                    r_rp[i] <= 1'b0;
                end else begin
                    if (w_push[i]) r_wp[i] <= ~r_wp[i];
                    if (w_pop[i])  r_rp[i] <= ~r_rp[i];
                end
            end
        end
    end

    // Storage needs no reset: an empty stage never exposes its contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wp[i]] <= w_in_data[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_stage_chain
// Purpose  : Self-checking bench. Four STAGES=3 instances (masks 101, 111,
//            011, 000) share the upstream stimulus; each is compared every
//            cycle against a queue-level model, plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_stage_chain;

    localparam int NI = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;

    logic [NI-1:0] d_ir;
    logic [NI-1:0] d_ov;
    logic [7:0]    d_od  [NI];
    logic [2:0]    d_occ [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_stage_chain #(.WIDTH(8), .STAGES(3), .REG_MASK(3'b101)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_ir[0]), .out_valid(d_ov[0]), .out_data(d_od[0]),
        .out_ready(out_ready), .occupancy(d_occ[0]));
    param_stage_chain #(.WIDTH(8), .STAGES(3), .REG_MASK(3'b111)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_ir[1]), .out_valid(d_ov[1]), .out_data(d_od[1]),
        .out_ready(out_ready), .occupancy(d_occ[1]));
    param_stage_chain #(.WIDTH(8), .STAGES(3), .REG_MASK(3'b011)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_ir[2]), .out_valid(d_ov[2]), .out_data(d_od[2]),
        .out_ready(out_ready), .occupancy(d_occ[2]));
    param_stage_chain #(.WIDTH(8), .STAGES(3), .REG_MASK(3'b000)) u_d (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_ir[3]), .out_valid(d_ov[3]), .out_data(d_od[3]),
        .out_ready(out_ready), .occupancy(d_occ[3]));

    // ---------------- reference model: each registered stage is a list of
    // up to two beats, index 0 being the oldest.
    logic [7:0] m_dat [NI][3][2];
    int         m_cnt [NI][3];

    function automatic logic [2:0] mask_of(input int k);
        case (k)
            0:       return 3'b101;
            1:       return 3'b111;
            2:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
    endtask

    task automatic model_outs(input int k, output logic ov, output logic [7:0] od,
                              output logic ir);
        logic [2:0] m = mask_of(k);
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 3; i++)
            if (m[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        if (first < 0) begin
            ov = in_valid;
            od = in_data;
            ir = out_ready & ~flush;
        end else begin
            ir = (m_cnt[k][first] < 2) && !flush;
            ov = (m_cnt[k][last] > 0);
            od = ov ? m_dat[k][last][0] : 8'h00;
        end
    endtask

    function automatic int model_occ(input int k);
        return m_cnt[k][0] + m_cnt[k][1] + m_cnt[k][2];
    endfunction

    task automatic model_step(input int k);
        logic [2:0] m = mask_of(k);
        logic       ov, ir;
        logic [7:0] od;
        logic       pop [3];
        logic       psh [3];
        logic [7:0] pv  [3];
        int         prev = -1;
        model_outs(k, ov, od, ir);
        for (int i = 0; i < 3; i++) begin
            pop[i] = 1'b0; psh[i] = 1'b0; pv[i] = 8'h00;
        end
        for (int i = 0; i < 3; i++)
            if (m[i]) begin
                if (prev < 0) begin
                    psh[i] = in_valid & ir;
                    pv[i]  = in_data;
                end else if (m_cnt[k][prev] > 0 && m_cnt[k][i] < 2) begin
                    pop[prev] = 1'b1;
                    psh[i]    = 1'b1;
                    pv[i]     = m_dat[k][prev][0];
                end
                prev = i;
            end
        if (prev >= 0 && ov && out_ready) pop[prev] = 1'b1;
        if (flush) begin
            for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pop[i]) begin
                    m_dat[k][i][0] = m_dat[k][i][1];
                    m_cnt[k][i]    = m_cnt[k][i] - 1;
                end
                if (psh[i]) begin
                    m_dat[k][i][m_cnt[k][i]] = pv[i];
                    m_cnt[k][i]              = m_cnt[k][i] + 1;
                end
            end
        end
    endtask

    // ---------------- checking
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        logic       ov, ir;
        logic [7:0] od;
        for (int k = 0; k < NI; k++) begin
            model_outs(k, ov, od, ir);
            chk($sformatf("model in_ready[%0d] t=%0t", k, $time), 32'(d_ir[k]), 32'(ir));
            chk($sformatf("model out_valid[%0d] t=%0t", k, $time), 32'(d_ov[k]), 32'(ov));
            chk($sformatf("model out_data[%0d] t=%0t", k, $time), 32'(d_od[k]), 32'(od));
            chk($sformatf("model occupancy[%0d] t=%0t", k, $time), 32'(d_occ[k]),
                32'(model_occ(k)));
        end
    endtask

    // Inputs change at posedge+1; outputs are checked at the negedge
    task automatic at_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic to_next();
        for (int k = 0; k < NI; k++) model_step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Passthrough instance vectors
    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        int   acc;
        int   got;
        int   first_ir;
        logic stop;

        vt[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1};
        vt[1] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        vt[2] = '{1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1};
        vt[3] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[5] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1};

        // ---- reset state
        model_reset();
        at_neg();
        chk("reset occ A", 32'(d_occ[0]), 32'd0);
        chk("reset out_valid A", 32'(d_ov[0]), 32'd0);
        chk("reset out_data A", 32'(d_od[0]), 32'd0);
        chk("reset in_ready A", 32'(d_ir[0]), 32'd1);
        chk("reset in_ready D", 32'(d_ir[3]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- pure passthrough vectors
        for (int n = 0; n < 6; n++) begin
            in_valid  = vt[n].iv;
            in_data   = vt[n].id;
            out_ready = vt[n].ordy;
            flush     = vt[n].fl;
            at_neg();
            chk($sformatf("pass ov v%0d", n), 32'(d_ov[3]), 32'(vt[n].e_ov));
            chk($sformatf("pass od v%0d", n), 32'(d_od[3]), 32'(vt[n].e_od));
            chk($sformatf("pass ir v%0d", n), 32'(d_ir[3]), 32'(vt[n].e_ir));
            chk($sformatf("pass occ v%0d", n), 32'(d_occ[3]), 32'd0);
            to_next();
        end
        do_reset();

        // ---- latency through mask 101
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        at_neg();
        chk("lat in_ready", 32'(d_ir[0]), 32'd1);
        to_next();
        in_valid = 1'b0;
        at_neg();
        chk("lat c1 ov", 32'(d_ov[0]), 32'd0);
        chk("lat c1 occ", 32'(d_occ[0]), 32'd1);
        to_next();
        at_neg();
        chk("lat c2 ov", 32'(d_ov[0]), 32'd1);
        chk("lat c2 od", 32'(d_od[0]), 32'hA5);
        chk("lat c2 occ", 32'(d_occ[0]), 32'd1);
        to_next();
        at_neg();
        chk("lat c3 ov", 32'(d_ov[0]), 32'd0);
        chk("lat c3 occ", 32'(d_occ[0]), 32'd0);
        to_next();
        do_reset();

        // ---- streaming through mask 111
        out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            in_valid = (c < 20);
            in_data  = 8'(c);
            at_neg();
            if (c < 20) chk($sformatf("stream ir c%0d", c), 32'(d_ir[1]), 32'd1);
            if (c >= 3 && c < 23) begin
                chk($sformatf("stream ov c%0d", c), 32'(d_ov[1]), 32'd1);
                chk($sformatf("stream od c%0d", c), 32'(d_od[1]), 32'(c - 3));
            end else begin
                chk($sformatf("stream idle c%0d", c), 32'(d_ov[1]), 32'd0);
            end
            to_next();
        end
        do_reset();

        // ---- backpressure through mask 011
        out_ready = 1'b0;
        acc  = 0;
        stop = 1'b0;
        for (int n = 0; n < 10 && !stop; n++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(acc);
            at_neg();
            if (!d_ir[2]) stop = 1'b1;
            else begin
                acc++;
                to_next();
            end
        end
        chk("bp accepted", 32'(acc), 32'd4);
        chk("bp occ full", 32'(d_occ[2]), 32'd4);
        chk("bp head ov", 32'(d_ov[2]), 32'd1);
        chk("bp head od", 32'(d_od[2]), 32'h40);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got       = 1;
        first_ir  = -1;
        for (int j = 0; j < 10; j++) begin
            to_next();
            at_neg();
            if (d_ov[2] && got < 4) begin
                chk($sformatf("bp drain %0d", got), 32'(d_od[2]), 32'h40 + 32'(got));
                got++;
            end
            if (first_ir < 0 && d_ir[2]) first_ir = j;
        end
        chk("bp drained", 32'(got), 32'd4);
        chk("bp ready rise", 32'(first_ir), 32'd1);
        chk("bp empty", 32'(d_occ[2]), 32'd0);
        to_next();
        do_reset();

        // ---- flush with simultaneous push on mask 111
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1;
            in_data  = 8'h21 + 8'(n);
            at_neg();
            to_next();
        end
        flush   = 1'b1;
        in_data = 8'h3C;
        at_neg();
        chk("flush occ before", 32'(d_occ[1]), 32'd3);
        chk("flush in_ready", 32'(d_ir[1]), 32'd0);
        to_next();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            chk($sformatf("flush occ c%0d", c), 32'(d_occ[1]), 32'd0);
            chk($sformatf("flush ov c%0d", c), 32'(d_ov[1]), 32'd0);
            to_next();
        end

        // ---- asynchronous reset mid-cycle on mask 011
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            in_data  = 8'h51 + 8'(n);
            at_neg();
            to_next();
        end
        in_valid = 1'b0;
        at_neg();
        chk("arst occ before", 32'(d_occ[2]), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst occ", 32'(d_occ[2]), 32'd0);
        chk("arst ov", 32'(d_ov[2]), 32'd0);
        chk("arst od", 32'(d_od[2]), 32'd0);
        chk("arst occ B", 32'(d_occ[1]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        at_neg();
        to_next();
        in_valid = 1'b0;
        at_neg();
        chk("arst post c1 ov", 32'(d_ov[2]), 32'd0);
        to_next();
        at_neg();
        chk("arst post c2 ov", 32'(d_ov[2]), 32'd1);
        chk("arst post c2 od", 32'(d_od[2]), 32'h11);
        to_next();

        // ---- randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            at_neg();
            to_next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_stage_chain.md
Name: param_stage_chain

Overview:
- Parametrised chain of STAGES data stages between an upstream valid/ready producer and a downstream consumer.
- Per-stage mode is set by a bit mask: each stage is either a combinational passthrough or a registered 2-entry elastic stage.
- Generalises a fixed passthrough-cell chain in width, depth and per-stage mode, and adds flow control, flush and occupancy reporting.
- Used in synthesis-frontend test designs to exercise parametrised instances that share one module body.

Parameters:
- WIDTH, 8, data bits per beat (>=1).
- STAGES, 2, number of chained stages (1..16).
- REG_MASK, 2'b01, STAGES-bit mask; bit i=1 makes stage i registered, bit i=0 makes it passthrough. Stage 0 is nearest the input.
- OCC_W, $clog2(2*STAGES+1), width of the occupancy output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all registered stages.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  upstream beat.
- in_ready  output  1  chain accepts a beat this cycle.
- out_valid  output  1  downstream beat valid.
- out_data  output  WIDTH  downstream beat.
- out_ready  input  1  downstream accepts a beat this cycle.
- occupancy  output  OCC_W  total beats held in registered stages.

Behaviour:
- Transfer rule: a transfer occurs on any interface when valid & ready are both high at a rising clk edge.
- Valid-hold rule: once valid is asserted, it and its data must hold until the transfer completes.
- Passthrough stage: out_valid=in_valid, out_data=in_data, in_ready=out_ready. Purely combinational; holds no state.
- Registered stage storage: 2-entry FIFO with a per-stage count of 0..2.
  - in_ready = (count != 2), driven from registers only. No combinational ready path through the stage.
  - out_valid = (count != 0); out_data = head entry.
- Registered stage update, applied simultaneously each edge:
  - push if in_valid & in_ready; pop if out_valid & out_ready.
  - push & pop together: count unchanged, data advances in order.
  - Push when empty: the beat appears at the output the next cycle (latency 1).
- Chain latency when empty = popcount(REG_MASK) cycles. REG_MASK=0 gives zero-latency wires.
- Throughput: 1 beat/cycle sustained when out_ready stays high. No bubbles are inserted at any stage boundary.
- Backpressure: with out_ready low, the chain absorbs 2*popcount(REG_MASK) beats, then in_ready drops.
  - in_ready reasserts the cycle after the first pop frees a slot in stage 0's registered path.
- Ordering: strict FIFO across the whole chain. No beat is dropped or duplicated.
- occupancy = sum of all registered-stage counts, registered, updated in the same cycle as the counts.
- Flush:
  - On an edge with flush=1, all counts go to 0 and any simultaneous push is discarded.
  - in_ready reads as low whenever flush=1.
  - Any pop on that edge still completes (the consumer saw valid & ready).
- Reset (async assert, sync release): counts=0, occupancy=0, out_valid=0.
  - in_ready=1 if stage 0 is registered; otherwise it follows downstream.
  - Storage data is don't-care, but out_data must be 0 at reset.
  - Reset mid-stream discards all held beats immediately, without waiting for a clock edge.
- Wrap-around: per-stage read/write pointers are 1 bit and toggle freely. count encodes full/empty; pointers are never compared for it.
- X-safety: out_data is 0 when out_valid=0 in registered output stages.

Test Plan:
- Latency: WIDTH=8, STAGES=3, REG_MASK=3'b101, out_ready=1; single beat 0xA5 -> out_valid high exactly 2 cycles later with 0xA5; occupancy 1,1,0.
- Streaming: REG_MASK=3'b111; 20 back-to-back beats 0..19 with out_ready=1 -> output 0..19 in order on consecutive cycles, in_ready never low.
- Backpressure: REG_MASK=3'b011, out_ready=0; push until in_ready=0 -> exactly 4 accepted, occupancy=4. Raise out_ready -> in_ready=1 one cycle after the first pop; all 4 beats drain in order.
- Flush with push: occupancy=3, flush=1 with in_valid=1 data 0x3C -> next cycle occupancy=0, out_valid=0; 0x3C never appears.
- Async reset: assert rst mid-cycle while occupancy=2 -> occupancy=0, out_valid=0 before the next edge; the post-release beat 0x11 passes with normal latency.
- Pure passthrough: REG_MASK=0 -> out_data==in_data and in_ready==out_ready in the same cycle; occupancy constantly 0.
